// File: rtl/dmem_arbiter.sv
// Two-requester data memory arbiter: round-robin grant, range check,
// read-modify-write for partial stores, one request in flight.
module dmem_arbiter #(
  parameter int MEM_SIZE = 9192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [1:0]  req0_size,
  input  logic [63:0] req0_addr,
  input  logic [63:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [1:0]  req1_size,
  input  logic [63:0] req1_addr,
  input  logic [63:0] req1_wdata,
  output logic        rsp0_valid,
  output logic [63:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [63:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        mem_rw,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam logic [63:0] LIMIT = 64'(MEM_SIZE - 8);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  logic        last;
  logic        grant;
  logic        idle_ok;
  logic        accept;
  logic        id_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [63:0] wdata_q;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] m;

  logic        a_we;
  logic [1:0]  a_size;
  logic [63:0] a_addr;
  logic [63:0] a_wdata;

  // Lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant = ~last;
    if (req0_valid && !req1_valid)
      grant = 1'b0;
    else if (req1_valid && !req0_valid)
      grant = 1'b1;
  end

  assign idle_ok    = (state == IDLE) && !rst;
  assign req0_ready = idle_ok && !grant;
  assign req1_ready = idle_ok && grant;
  assign accept     = grant ? req1_ready && req1_valid
                            : req0_ready && req0_valid;

  assign a_we    = grant ? req1_we    : req0_we;
  assign a_size  = grant ? req1_size  : req0_size;
  assign a_addr  = grant ? req1_addr  : req0_addr;
  assign a_wdata = grant ? req1_wdata : req0_wdata;

  always_comb begin
    m = '1;
    unique case (size_q)
      2'd0: m = 64'h0000_0000_0000_00ff;
      2'd1: m = 64'h0000_0000_0000_ffff;
      2'd2: m = 64'h0000_0000_ffff_ffff;
      2'd3: m = '1;
    endcase
  end

  assign rsp0_rdata = rsp_rdata;
  assign rsp1_rdata = rsp_rdata;
  assign rsp0_err   = rsp_err;
  assign rsp1_err   = rsp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      wdata_q    <= '0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            last      <= grant;
            id_q      <= grant;
            we_q      <= a_we;
            size_q    <= a_size;
            wdata_q   <= a_wdata;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (a_addr > LIMIT) begin
              rsp_err    <= 1'b1;
              rsp0_valid <= ~grant;
              rsp1_valid <= grant;
              state      <= RESP;
            end else begin
              mem_addr <= a_addr;
              if (a_we && a_size == 2'd3) begin
                mem_rw    <= 1'b1;
                mem_wdata <= a_wdata;
                state     <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          if (we_q) begin
            mem_wdata <= (mem_rdata & ~m) | (wdata_q & m);
            mem_rw    <= 1'b1;
            state     <= WRITE;
          end else begin
            rsp_rdata  <= mem_rdata & m;
            rsp0_valid <= ~id_q;
            rsp1_valid <= id_q;
            state      <= RESP;
          end
        end
        WRITE: begin
          mem_rw     <= 1'b0;
          rsp0_valid <= ~id_q;
          rsp1_valid <= id_q;
          state      <= RESP;
        end
        RESP: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: byte memory on the bus, reference
// memory model and response scoreboard.
module tb_dmem_arbiter;

  localparam int MEM = 9192;
  localparam logic [63:0] LIM = 64'(MEM - 8);

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [1:0]  req0_size;
  logic [63:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [1:0]  req1_size;
  logic [63:0] req1_addr, req1_wdata;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [63:0] rsp0_rdata, rsp1_rdata;
  logic        mem_rw;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.MEM_SIZE(MEM)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_we(req0_we), .req0_size(req0_size),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_we(req1_we), .req1_size(req1_size),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp1_err(rsp1_err),
    .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        we;
    logic [1:0]  sz;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } ent_t;

  logic [7:0]  mem [MEM];
  logic        wr_tick;
  logic [7:0]  mdl [logic [63:0]];
  ent_t        sb [$];
  int          gq [$];
  int          rcnt [2];
  int          cyc;
  int          nw;
  int          errors;
  int          checks;
  logic [63:0] last_rdata;
  logic        last_err;
  int          last_lat;

  always @(mem_addr or wr_tick) begin
    mem_rdata = '0;
    if (mem_addr <= LIM)
      for (int i = 0; i < 8; i++)
        mem_rdata[8*i +: 8] = mem[int'(mem_addr[31:0]) + i];
  end

  always @(negedge clk) begin
    if (mem_rw && mem_addr <= LIM) begin
      for (int i = 0; i < 8; i++)
        mem[int'(mem_addr[31:0]) + i] <= mem_wdata[8*i +: 8];
      wr_tick <= ~wr_tick;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mread(input logic [63:0] a);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < 8; i++)
      if (mdl.exists(a + 64'(i))) d[8*i +: 8] = mdl[a + 64'(i)];
    return d;
  endfunction

  function automatic logic [63:0] msk(input logic [1:0] sz);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < (1 << sz); i++) r[8*i +: 8] = 8'hff;
    return r;
  endfunction

  task automatic push_acc(input int id, input logic we,
                          input logic [1:0] sz,
                          input logic [63:0] a, wd);
    ent_t e;
    gq.push_back(id);
    e.id = id; e.we = we; e.sz = sz; e.addr = a; e.wdata = wd;
    e.acc = cyc + 1;
    e.err = (a > LIM);
    e.rdata = '0;
    if (e.err) e.lat = 1;
    else if (we) e.lat = (sz == 2'd3) ? 2 : 3;
    else begin
      e.lat = 2;
      e.rdata = mread(a) & msk(sz);
    end
    sb.push_back(e);
  endtask

  // Response checking and acceptance capture, away from the clock edge.
  always @(negedge clk) begin
    ent_t e;
    int id;
    if (rst) sb.delete();
    else begin
      if (mem_rw) nw++;
      if (rsp0_valid || rsp1_valid) begin
        chk("rsp_onehot", 64'(rsp0_valid && rsp1_valid), 0);
        id = rsp1_valid ? 1 : 0;
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          last_rdata = id ? rsp1_rdata : rsp0_rdata;
          last_err = id ? rsp1_err : rsp0_err;
          last_lat = cyc - e.acc + 1;
          chk("rsp_id", 64'(id), 64'(e.id));
          chk("rsp_rdata", last_rdata, e.rdata);
          chk("rsp_err", 64'(last_err), 64'(e.err));
          chk("rsp_lat", 64'(last_lat), 64'(e.lat));
          if (e.we && !e.err)
            for (int i = 0; i < (1 << e.sz); i++)
              mdl[e.addr + 64'(i)] = e.wdata[8*i +: 8];
          rcnt[id]++;
        end
      end
      if (req0_valid && req0_ready)
        push_acc(0, req0_we, req0_size, req0_addr, req0_wdata);
      if (req1_valid && req1_ready)
        push_acc(1, req1_we, req1_size, req1_addr, req1_wdata);
    end
  end

  task automatic start(input int id, input logic we,
                       input logic [1:0] sz,
                       input logic [63:0] a, wd);
    if (id == 0) begin
      req0_we = we; req0_size = sz; req0_addr = a;
      req0_wdata = wd; req0_valid = 1'b1;
    end else begin
      req1_we = we; req1_size = sz; req1_addr = a;
      req1_wdata = wd; req1_valid = 1'b1;
    end
  endtask

  task automatic wait_accept(input int id);
    int k;
    logic hit;
    k = 0;
    hit = 1'b0;
    while (!hit && k < 50) begin
      @(negedge clk);
      hit = (id == 0) ? (req0_valid && req0_ready)
                      : (req1_valid && req1_ready);
      k++;
    end
    if (!hit) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) chk("done_timeout", 64'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input logic we,
                       input logic [1:0] sz,
                       input logic [63:0] a, wd);
    start(id, we, sz, a, wd);
    wait_accept(id);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, c0, c1, w0, n0;
    logic [63:0] a0;
    errors = 0; checks = 0; cyc = 0; nw = 0;
    rcnt[0] = 0; rcnt[1] = 0;
    wr_tick = 1'b0;
    for (int i = 0; i < MEM; i++) mem[i] = 8'h00;
    wr_tick = 1'b1;
    rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_size = 0;
    req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_size = 0;
    req1_addr = 0; req1_wdata = 0;
    start(0, 1'b0, 2'd3, 64'h0, 64'h0);
    start(1, 1'b0, 2'd3, 64'h8, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", 64'(req0_ready), 0);
    chk("rst_ready1", 64'(req1_ready), 0);
    chk("rst_mem_rw", 64'(mem_rw), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 0);
    chk("rst_rsp", rsp0_rdata | rsp1_rdata, 0);
    chk("rst_err", 64'({rsp0_err, rsp1_err}), 0);
    rst = 1'b0;
    wait_accept(0);
    wait_accept(1);
    wait_done();
    chk("rr_count", 64'(gq.size()), 2);
    if (gq.size() == 2) begin
      chk("rr_first", 64'(gq[0]), 0);
      chk("rr_second", 64'(gq[1]), 1);
    end

    issue(0, 1'b1, 2'd3, 64'h10, 64'h0C3C3EAAF00FCC33);
    issue(0, 1'b0, 2'd3, 64'h10, 64'h0);
    chk("ld_full_data", last_rdata, 64'h0C3C3EAAF00FCC33);
    chk("ld_full_lat", 64'(last_lat), 2);
    chk("ld_full_err", 64'(last_err), 0);

    w0 = nw;
    issue(1, 1'b1, 2'd0, 64'h10, 64'hFF);
    chk("ps_lat", 64'(last_lat), 3);
    chk("ps_write_cycles", 64'(nw - w0), 1);
    issue(1, 1'b0, 2'd3, 64'h10, 64'h0);
    chk("ps_data", last_rdata, 64'h0C3C3EAAF00FCCFF);

    b = gq.size(); c0 = rcnt[0]; c1 = rcnt[1];
    start(0, 1'b0, 2'd3, 64'h10, 64'h0);
    start(1, 1'b0, 2'd1, 64'h10, 64'h0);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (gq.size() - b >= 4) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_done();
    chk("cont_grants", 64'(gq.size() - b), 4);
    if (gq.size() - b == 4)
      for (int k = 0; k < 4; k++)
        chk("cont_order", 64'(gq[b + k]), 64'(k % 2));
    chk("cont_rsp0", 64'(rcnt[0] - c0), 2);
    chk("cont_rsp1", 64'(rcnt[1] - c1), 2);

    a0 = mem_addr; w0 = nw;
    issue(0, 1'b0, 2'd3, 64'(MEM - 7), 64'h0);
    chk("rng_hi_err", 64'(last_err), 1);
    chk("rng_hi_lat", 64'(last_lat), 1);
    issue(1, 1'b0, 2'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    chk("rng_wrap_err", 64'(last_err), 1);
    chk("rng_wrap_lat", 64'(last_lat), 1);
    chk("rng_no_write", 64'(nw - w0), 0);
    chk("rng_addr_hold", mem_addr, a0);
    issue(0, 1'b0, 2'd3, 64'(MEM - 8), 64'h0);
    chk("rng_edge_err", 64'(last_err), 0);
    chk("rng_edge_lat", 64'(last_lat), 2);

    issue(0, 1'b1, 2'd3, 64'h20, 64'h0C3C3EAAF00FCC33);
    issue(0, 1'b0, 2'd0, 64'h20, 64'h0);
    chk("zx_byte", last_rdata, 64'h33);
    issue(1, 1'b0, 2'd1, 64'h20, 64'h0);
    chk("zx_half", last_rdata, 64'hCC33);
    issue(0, 1'b0, 2'd2, 64'h20, 64'h0);
    chk("zx_word", last_rdata, 64'hF00FCC33);

    issue(1, 1'b1, 2'd3, 64'h40, 64'h1122334455667788);
    n0 = rcnt[0] + rcnt[1];
    start(0, 1'b1, 2'd3, 64'h40, 64'hDEADBEEFCAFEF00D);
    wait_accept(0);
    chk("wr_active", 64'(mem_rw), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_abort_rw", 64'(mem_rw), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_rsp", 64'(rcnt[0] + rcnt[1] - n0), 0);
    chk("rst_mem_byte", 64'(mem[64]), 64'h88);
    issue(1, 1'b0, 2'd3, 64'h40, 64'h0);
    chk("rst_mem_word", last_rdata, 64'h1122334455667788);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
